// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults and helpers for the scoreboard register file.
package rf_pkg;
   localparam int RF_DATA_W_DEF   = 32;
   localparam int RF_ADDR_W_DEF   = 5;
   localparam int RF_NUM_READ_DEF = 2;
   localparam int RF_ZERO_ADDR    = 0;
   function automatic logic rf_is_zero(input logic [31:0] addr);
      return addr == 32'(RF_ZERO_ADDR);
   endfunction
endpackage

// File: rtl/rf_busy_table.sv
// rf_busy_table: per-register busy scoreboard; flush beats issue beats writeback.
module rf_busy_table
   import rf_pkg::*;
#(
   parameter int ADDR_W = RF_ADDR_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 issue_en,
   input  logic [ADDR_W-1:0]    issue_addr,
   input  logic                 wr_en,
   input  logic [ADDR_W-1:0]    wr_addr,
   input  logic                 flush,
   output logic [2**ADDR_W-1:0] busy_vec
);
   localparam int DEPTH = 2**ADDR_W;
   logic [DEPTH-1:0] busy_q, busy_d;
   // Later assignments override earlier ones, giving the precedence order.
   always_comb begin
      busy_d = busy_q;
      if (wr_en) busy_d[wr_addr] = 1'b0;
      if (issue_en && !rf_is_zero(32'(issue_addr))) busy_d[issue_addr] = 1'b1;
      if (flush) busy_d = '0;
      busy_d[RF_ZERO_ADDR] = 1'b0;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end
   assign busy_vec = busy_q;
endmodule

// File: rtl/rf_scoreboard_regfile.sv
// rf_scoreboard_regfile: multi-port register file with busy scoreboard and decode stall.
// Define RF_BYPASS_EN for same-cycle write-through forwarding on every read port.
module rf_scoreboard_regfile
   import rf_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W_DEF,
   parameter int ADDR_W   = RF_ADDR_W_DEF,
   parameter int NUM_READ = RF_NUM_READ_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [ADDR_W-1:0]          wr_addr,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic [NUM_READ*ADDR_W-1:0] rd_addr,
   output logic [NUM_READ*DATA_W-1:0] rd_data,
   output logic [NUM_READ-1:0]        rd_busy,
   output logic                       stall,
   input  logic                       issue_en,
   input  logic [ADDR_W-1:0]          issue_addr,
   input  logic                       flush
);
   localparam int DEPTH = 2**ADDR_W;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]  busy_vec;
   rf_busy_table #(.ADDR_W(ADDR_W)) u_busy (
      .clk        (clk),
      .rst        (rst),
      .issue_en   (issue_en),
      .issue_addr (issue_addr),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .flush      (flush),
      .busy_vec   (busy_vec)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                       mem_q <= '{default: '0};
      else if (wr_en && !rf_is_zero(32'(wr_addr)))   mem_q[wr_addr] <= wr_data;
   end
   for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
      logic [ADDR_W-1:0] a;
      assign a = rd_addr[i*ADDR_W +: ADDR_W];
`ifdef RF_BYPASS_EN
      // A value landing this cycle is forwarded, so it is no longer a hazard.
      logic fwd;
      assign fwd = wr_en && wr_addr == a;
      assign rd_data[i*DATA_W +: DATA_W] = rf_is_zero(32'(a)) ? '0 : (fwd ? wr_data : mem_q[a]);
      assign rd_busy[i] = busy_vec[a] & ~fwd;
`else
      assign rd_data[i*DATA_W +: DATA_W] = rf_is_zero(32'(a)) ? '0 : mem_q[a];
      assign rd_busy[i] = busy_vec[a];
`endif
   end
   assign stall = |rd_busy;
endmodule

// File: tb/tb_rf_scoreboard_regfile.sv
// tb_rf_scoreboard_regfile: directed and random stimulus against a queue-based scoreboard.
module tb_rf_scoreboard_regfile;
`ifdef RF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [4:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic [9:0]  rd_addr = '0;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic        stall;
   logic        issue_en = 1'b0;
   logic [4:0]  issue_addr = '0;
   logic        flush = 1'b0;

   rf_scoreboard_regfile dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_busy    (rd_busy),
      .stall      (stall),
      .issue_en   (issue_en),
      .issue_addr (issue_addr),
      .flush      (flush)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] d [2];
      logic [1:0]  b;
      logic        s;
   } exp_t;

   exp_t        sb_q [$];
   event        chk_ev;
   int          n_chk = 0;
   int          n_pass = 0;
   logic [31:0] mem_m [32];
   bit          busy_m [32];

   function automatic logic [31:0] exp_data(input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (BYP && wr_en && wr_addr == a) return wr_data;
      return mem_m[a];
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
      return busy_m[a] && !(BYP && wr_en && wr_addr == a);
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 32; k++) begin
         mem_m[k] = '0;
         busy_m[k] = 1'b0;
      end
   endtask

   task automatic model_edge();
      if (wr_en && wr_addr != 0) mem_m[wr_addr] = wr_data;
      if (flush) begin
         for (int k = 0; k < 32; k++) busy_m[k] = 1'b0;
      end else begin
         if (wr_en) busy_m[wr_addr] = 1'b0;
         if (issue_en && issue_addr != 0) busy_m[issue_addr] = 1'b1;
      end
   endtask

   task automatic push_check(input string name);
      exp_t e;
      e.name = name;
      for (int p = 0; p < 2; p++) begin
         e.d[p] = exp_data(rd_addr[p*5 +: 5]);
         e.b[p] = exp_busy(rd_addr[p*5 +: 5]);
      end
      e.s = |e.b;
      sb_q.push_back(e);
      -> chk_ev;
      #1;
   endtask

   task automatic step(input string name, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r0, input logic [4:0] r1, input bit ie, input logic [4:0] ia,
                       input bit fl);
      @(negedge clk);
      wr_en = we; wr_addr = wa; wr_data = wd;
      rd_addr = {r1, r0};
      issue_en = ie; issue_addr = ia; flush = fl;
      #1;
      push_check(name);
      @(posedge clk);
      if (!rst) model_edge();
   endtask

   task automatic idle(input string name, input logic [4:0] r0, input logic [4:0] r1);
      step(name, 1'b0, 5'd0, 32'd0, r0, r1, 1'b0, 5'd0, 1'b0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(chk_ev);
         while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            for (int p = 0; p < 2; p++) begin
               n_chk++;
               if (rd_data[p*32 +: 32] === e.d[p]) n_pass++;
               else $display("FAIL %s rd_data[%0d] got %h expected %h", e.name, p, rd_data[p*32 +: 32], e.d[p]);
            end
            n_chk++;
            if (rd_busy === e.b) n_pass++;
            else $display("FAIL %s rd_busy got %b expected %b", e.name, rd_busy, e.b);
            n_chk++;
            if (stall === e.s) n_pass++;
            else $display("FAIL %s stall got %b expected %b", e.name, stall, e.s);
         end
      end
   end

   initial begin : driver
      model_clear();
      rst = 1'b1;
      idle("reset_state", 5'd20, 5'd7);
      idle("reset_hold", 5'd1, 5'd31);
      @(negedge clk);
      rst = 1'b0;
      step("wr20_same_cycle", 1'b1, 5'd20, 32'd50, 5'd0, 5'd20, 1'b0, 5'd0, 1'b0);
      idle("rd20_after", 5'd20, 5'd20);
      step("wr0_discard", 1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
      step("issue0", 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
      idle("rd0_after", 5'd0, 5'd0);
      step("issue7", 1'b0, 5'd0, 32'd0, 5'd7, 5'd1, 1'b1, 5'd7, 1'b0);
      idle("rd7_busy", 5'd7, 5'd7);
      step("wb7", 1'b1, 5'd7, 32'd9, 5'd7, 5'd20, 1'b0, 5'd0, 1'b0);
      idle("rd7_cleared", 5'd7, 5'd7);
      step("issue_wb7_same", 1'b1, 5'd7, 32'd11, 5'd7, 5'd0, 1'b1, 5'd7, 1'b0);
      idle("rd7_reserved", 5'd7, 5'd1);
      step("issue3", 1'b0, 5'd0, 32'd0, 5'd3, 5'd4, 1'b1, 5'd3, 1'b0);
      step("issue4", 1'b0, 5'd0, 32'd0, 5'd3, 5'd4, 1'b1, 5'd4, 1'b0);
      step("issue5", 1'b0, 5'd0, 32'd0, 5'd5, 5'd4, 1'b1, 5'd5, 1'b0);
      step("flush_issue6", 1'b0, 5'd0, 32'd0, 5'd3, 5'd6, 1'b1, 5'd6, 1'b1);
      idle("post_flush_36", 5'd3, 5'd6);
      idle("post_flush_45", 5'd4, 5'd5);
      idle("post_flush_7", 5'd7, 5'd7);
      step("issue20", 1'b0, 5'd0, 32'd0, 5'd20, 5'd20, 1'b1, 5'd20, 1'b0);
      idle("rd20_busy", 5'd20, 5'd20);
      // Asynchronous reset asserted between clock edges.
      @(negedge clk);
      wr_en = 1'b0; issue_en = 1'b0; flush = 1'b0;
      rd_addr = {5'd20, 5'd20};
      #1;
      rst = 1'b1;
      #1;
      model_clear();
      push_check("async_reset");
      @(negedge clk);
      rst = 1'b0;
      idle("rd20_after_reset", 5'd20, 5'd7);
      for (int n = 0; n < 400; n++) begin
         step("random",
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
              1'($urandom_range(0, 15) == 0));
      end
      idle("final", 5'd1, 5'd2);
      #2;
      n_chk++;
      if (sb_q.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain got %0d pending expected 0", sb_q.size());
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
